cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
- Shares one comparator instance between two execute-stage requesters: the branch unit (BEQ/BNE/BLT/BGE/BLTU/BGEU) and the ALU set-less-than path (SLT/SLTU).
- Round-robin arbitration, valid/ready handshakes on every port, and a single registered result stage, so latency is one cycle.
- Sits between the issue/execute logic and the writeback and branch-redirect logic.

Parameters:
- BUS_WIDTH, 64, operand width passed to the comparator.
- TAG_W, 5, width of the opaque requester tag (ROB/dest index) carried with each request.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pipeline flush; kills branch-side traffic only.
- br_valid  in  1  branch request valid.
- br_ready  out  1  branch request accepted this cycle.
- br_in1  in  BUS_WIDTH  rs1 value.
- br_in2  in  BUS_WIDTH  rs2 value.
- br_op  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- br_tag  in  TAG_W  branch tag.
- slt_valid  in  1  set-less-than request valid.
- slt_ready  out  1  set-less-than request accepted.
- slt_in1  in  BUS_WIDTH  operand 1.
- slt_in2  in  BUS_WIDTH  operand 2.
- slt_unsigned  in  1  1 = SLTU, 0 = SLT.
- slt_tag  in  TAG_W  SLT tag.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_src  out  1  0 = branch, 1 = slt.
- res_tag  out  TAG_W  tag of the granted request.
- res_bit  out  1  branch taken, or less-than result.
- res_zero  out  1  raw comparator flag: in1 == in2.
- res_neg  out  1  raw comparator flag: signed in1 < in2.
- res_negu  out  1  raw comparator flag: unsigned in1 < in2.
- res_illegal  out  1  br_op was 010 or 011.

Behaviour:
- Reset: res_valid, res_src, res_tag, res_bit, res_zero, res_neg, res_negu and res_illegal all 0. Round-robin pointer last_grant = slt, so the branch port wins the first conflict.
- Output register state machine:
  - EMPTY: res_valid = 0.
  - FULL: res_valid = 1.
  - can_accept = EMPTY | (res_valid & res_ready).
- Grant, combinational:
  - Only one requester valid: that one is granted if can_accept.
  - Both valid: grant the port other than last_grant.
  - br_valid is masked by flush.
  - br_ready = grant_br & can_accept. slt_ready = grant_slt & can_accept.
  - At most one ready is high per cycle.
- Datapath:
  - The granted operands are muxed into the single comparator instance.
  - On a handshake the register captures src, tag and the three flags.
  - It also captures res_bit:
    - BEQ: zero. BNE: !zero.
    - BLT: neg. BGE: !neg.
    - BLTU: negu. BGEU: !negu.
    - SLT: neg. SLTU: negu.
  - br_op 010 or 011: res_bit = 0, res_illegal = 1. The request is still consumed.
  - Latency: request handshake in cycle N, res_valid in cycle N+1.
- last_grant updates only on a successful handshake. It never changes on a stall.
- Back-pressure:
  - While FULL and res_ready = 0, both ready outputs are 0 and the output register holds every field stable.
  - Requesters must hold valid and their payload until ready.
- Simultaneous drain and fill: res_valid & res_ready together with a new grant reloads the register the same cycle. No bubble, so full throughput is one result per cycle.
- Flush:
  - Asserted while the register holds a branch result (res_src = 0): the register clears to EMPTY next cycle, whether or not res_ready is set.
  - A held slt result is unaffected.
  - No branch request is accepted in a flush cycle. An slt request may be accepted in that cycle.
- rst has priority over flush and over any handshake.
- Mid-operation reset: the held result is discarded and the pointer is restored to its reset value.

Decomposition:
- Shared package cmp_pkg holds:
  - BR_* funct3 localparams.
  - RES_SRC_BR / RES_SRC_SLT.
  - The flag-to-result select function used by the branch unit elsewhere.
- One sub-module, comparator, instantiated once. The arbiter and output register stay inline.

Test Plan:
- Single branch: br_op = 000, in1 = in2 = 0x5 → br_ready same cycle; next cycle res_valid = 1, res_src = 0, res_bit = 1, res_zero = 1.
- Signed vs unsigned: SLT with in1 = 0xFFFF_FFFF_FFFF_FFFF, in2 = 1 gives res_bit = 1; SLTU with the same operands gives res_bit = 0, res_negu = 0.
- Conflict round-robin: both ports valid for 4 cycles with res_ready = 1 → grants are br, slt, br, slt; tags appear in that order on back-to-back cycles.
- Back-pressure: res_ready = 0 for 3 cycles with a BLTU result held → res fields stable, br_ready = slt_ready = 0; on release the next result follows with no bubble.
- Flush: flush asserted while a branch result is held and res_ready = 0 → res_valid = 0 next cycle. A simultaneous slt_valid is accepted and appears the following cycle.
- Illegal/reset: br_op = 010 → res_illegal = 1, res_bit = 0. rst asserted with a result held → res_valid = 0 next cycle, and the next conflict grants br.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared funct3 codes, result-source encoding and branch flag-to-result select
package cmp_pkg;
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;
  localparam logic RES_SRC_BR  = 1'b0;
  localparam logic RES_SRC_SLT = 1'b1;
  function automatic logic br_illegal(input logic [2:0] op);
    return op == 3'b010 || op == 3'b011;
  endfunction
  function automatic logic br_taken(input logic [2:0] op, input logic zero, input logic neg, input logic negu);
    return op == BR_BEQ  ? zero  :
           op == BR_BNE  ? !zero :
           op == BR_BLT  ? neg   :
           op == BR_BGE  ? !neg  :
           op == BR_BLTU ? negu  :
           op == BR_BGEU ? !negu : 1'b0;
  endfunction
endpackage

// File: rtl/cmp_arbiter_comparator.sv
// comparator: equality, signed and unsigned less-than flags of two operands
module comparator #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         zero,
  output logic         neg,
  output logic         negu
);
  assign zero = a == b;
  assign neg  = $signed(a) < $signed(b);
  assign negu = a < b;
endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin sharing of one comparator between branch and slt requesters with a registered result stage
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [BUS_WIDTH-1:0] br_in1,
  input  logic [BUS_WIDTH-1:0] br_in2,
  input  logic [2:0]           br_op,
  input  logic [TAG_W-1:0]     br_tag,
  input  logic                 slt_valid,
  output logic                 slt_ready,
  input  logic [BUS_WIDTH-1:0] slt_in1,
  input  logic [BUS_WIDTH-1:0] slt_in2,
  input  logic                 slt_unsigned,
  input  logic [TAG_W-1:0]     slt_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_src,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 res_bit,
  output logic                 res_zero,
  output logic                 res_neg,
  output logic                 res_negu,
  output logic                 res_illegal
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic last_grant, gnt_br, gnt_slt, can_accept, hs, zero, neg, negu;
  logic [BUS_WIDTH-1:0] a, b;
  always_comb begin
    can_accept = state == EMPTY || res_ready;
    gnt_br     = br_valid && !flush && (!slt_valid || last_grant == RES_SRC_SLT);
    gnt_slt    = slt_valid && !gnt_br;
    br_ready   = gnt_br && can_accept;
    slt_ready  = gnt_slt && can_accept;
    hs         = br_ready || slt_ready;
    a          = gnt_slt ? slt_in1 : br_in1;
    b          = gnt_slt ? slt_in2 : br_in2;
  end
  comparator #(.W(BUS_WIDTH)) u_cmp (.a(a), .b(b), .zero(zero), .neg(neg), .negu(negu));
  assign res_valid = state == FULL;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      last_grant  <= RES_SRC_SLT;
      res_src     <= 1'b0;
      res_tag     <= '0;
      res_bit     <= 1'b0;
      res_zero    <= 1'b0;
      res_neg     <= 1'b0;
      res_negu    <= 1'b0;
      res_illegal <= 1'b0;
    end else if (hs) begin
      state       <= FULL;
      last_grant  <= gnt_slt;
      res_src     <= gnt_slt ? RES_SRC_SLT : RES_SRC_BR;
      res_tag     <= gnt_slt ? slt_tag : br_tag;
      res_bit     <= gnt_slt ? (slt_unsigned ? negu : neg) : br_taken(br_op, zero, neg, negu);
      res_zero    <= zero;
      res_neg     <= neg;
      res_negu    <= negu;
      res_illegal <= !gnt_slt && br_illegal(br_op);
    end else if (state == FULL && (res_ready || (flush && res_src == RES_SRC_BR))) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed stimulus checked by a per-cycle behavioural model plus literal expectations
module tb_cmp_arbiter;
  localparam int W = 64;
  localparam int T = 5;
  logic clk = 0, rst = 1, flush = 0;
  logic br_valid = 0, slt_valid = 0, slt_unsigned = 0, res_ready = 0;
  logic br_ready, slt_ready, res_valid, res_src, res_bit, res_zero, res_neg, res_negu, res_illegal;
  logic [W-1:0] br_in1 = 0, br_in2 = 0, slt_in1 = 0, slt_in2 = 0;
  logic [2:0] br_op = 0;
  logic [T-1:0] br_tag = 0, slt_tag = 0, res_tag;
  int checks = 0, errors = 0;
  cmp_arbiter #(.BUS_WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .br_valid(br_valid), .br_ready(br_ready), .br_in1(br_in1), .br_in2(br_in2), .br_op(br_op), .br_tag(br_tag),
    .slt_valid(slt_valid), .slt_ready(slt_ready), .slt_in1(slt_in1), .slt_in2(slt_in2),
    .slt_unsigned(slt_unsigned), .slt_tag(slt_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src), .res_tag(res_tag), .res_bit(res_bit),
    .res_zero(res_zero), .res_neg(res_neg), .res_negu(res_negu), .res_illegal(res_illegal)
  );
  always #5 clk = ~clk;
  logic m_valid = 0, m_last = 1, m_src = 0, m_bit = 0, m_zero = 0, m_neg = 0, m_negu = 0, m_ill = 0;
  logic [T-1:0] m_tag = 0;
  logic n_valid, n_last, n_src, n_bit, n_zero, n_neg, n_negu, n_ill;
  logic [T-1:0] n_tag;
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic branch_result(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return $signed(x) < $signed(y);
      3'b101: return $signed(x) >= $signed(y);
      3'b110: return x < y;
      3'b111: return x >= y;
      default: return 1'b0;
    endcase
  endfunction
  always @(negedge clk) begin
    logic want_br, want_slt, take_br, take_slt, room;
    logic [W-1:0] x, y;
    want_br  = br_valid && !flush;
    want_slt = slt_valid;
    room     = !m_valid || res_ready;
    take_slt = want_slt && (!want_br || m_last == 1'b0) && room;
    take_br  = want_br && (!want_slt || m_last == 1'b1) && room;
    {n_valid, n_last, n_src, n_bit, n_zero, n_neg, n_negu, n_ill, n_tag} =
      {m_valid, m_last, m_src, m_bit, m_zero, m_neg, m_negu, m_ill, m_tag};
    if (rst) begin
      {n_valid, n_src, n_bit, n_zero, n_neg, n_negu, n_ill, n_tag} = '0;
      n_last = 1'b1;
    end else begin
      chk("br_ready", br_ready, take_br);
      chk("slt_ready", slt_ready, take_slt);
      chk("res_valid", res_valid, m_valid);
      if (m_valid) begin
        chk("res_src", res_src, m_src);
        chk("res_tag", res_tag, m_tag);
        chk("res_bit", res_bit, m_bit);
        chk("res_flags", {res_zero, res_neg, res_negu, res_illegal}, {m_zero, m_neg, m_negu, m_ill});
      end
      if (take_br || take_slt) begin
        x = take_slt ? slt_in1 : br_in1;
        y = take_slt ? slt_in2 : br_in2;
        n_valid = 1;
        n_last  = take_slt;
        n_src   = take_slt;
        n_tag   = take_slt ? slt_tag : br_tag;
        n_zero  = x == y;
        n_neg   = $signed(x) < $signed(y);
        n_negu  = x < y;
        n_ill   = take_br && (br_op == 3'b010 || br_op == 3'b011);
        n_bit   = take_slt ? (slt_unsigned ? x < y : $signed(x) < $signed(y)) : branch_result(br_op, x, y);
      end else if (m_valid && (res_ready || (flush && m_src == 1'b0))) begin
        n_valid = 0;
      end
    end
  end
  always @(posedge clk) begin
    {m_valid, m_last, m_src, m_bit, m_zero, m_neg, m_negu, m_ill, m_tag} <=
      {n_valid, n_last, n_src, n_bit, n_zero, n_neg, n_negu, n_ill, n_tag};
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc();
    cyc();
    rst = 0;
    chk("rst_fields", {res_valid, res_src, res_tag, res_bit, res_zero, res_neg, res_negu, res_illegal}, 0);
    res_ready = 1;
    br_valid = 1; br_op = 3'b000; br_in1 = 5; br_in2 = 5; br_tag = 3;
    #1 chk("beq_ready", br_ready, 1);
    cyc();
    br_valid = 0;
    chk("beq_valid", res_valid, 1);
    chk("beq_src", res_src, 0);
    chk("beq_bit", res_bit, 1);
    chk("beq_zero", res_zero, 1);
    chk("beq_tag", res_tag, 3);
    slt_valid = 1; slt_unsigned = 0; slt_in1 = '1; slt_in2 = 1; slt_tag = 7;
    cyc();
    chk("slt_bit", res_bit, 1);
    chk("slt_neg", res_neg, 1);
    slt_unsigned = 1; slt_tag = 8;
    cyc();
    chk("sltu_bit", res_bit, 0);
    chk("sltu_negu", res_negu, 0);
    chk("sltu_tag", res_tag, 8);
    br_valid = 1; br_op = 3'b000; br_tag = 10;
    slt_tag = 20; slt_unsigned = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_src", res_src, i % 2);
      chk("rr_tag", res_tag, i == 0 ? 10 : i == 1 ? 20 : i == 2 ? 11 : 21);
      if (i % 2 == 0) br_tag = br_tag + 1;
      else slt_tag = slt_tag + 1;
    end
    slt_valid = 0;
    br_op = 3'b110; br_in1 = 1; br_in2 = 2; br_tag = 5;
    cyc();
    br_valid = 0; res_ready = 0;
    slt_valid = 1; slt_in1 = 3; slt_in2 = 4; slt_tag = 9;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold", {res_valid, res_src, res_tag, res_bit, res_negu}, {1'b1, 1'b0, 5'd5, 1'b1, 1'b1});
      chk("bp_ready", {br_ready, slt_ready}, 0);
    end
    res_ready = 1;
    #1 chk("bp_release", slt_ready, 1);
    cyc();
    slt_valid = 0;
    chk("bp_next", {res_valid, res_src, res_tag}, {1'b1, 1'b1, 5'd9});
    br_valid = 1; br_op = 3'b001; br_in1 = 1; br_in2 = 2; br_tag = 4;
    cyc();
    br_valid = 0; res_ready = 0; flush = 1;
    slt_valid = 1; slt_tag = 12;
    cyc();
    flush = 0;
    chk("flush_empty", res_valid, 0);
    #1 chk("flush_slt_rdy", slt_ready, 1);
    cyc();
    slt_valid = 0;
    chk("flush_slt", {res_valid, res_src, res_tag}, {1'b1, 1'b1, 5'd12});
    res_ready = 1;
    br_valid = 1; br_op = 3'b010; br_tag = 6;
    cyc();
    br_valid = 0; res_ready = 0;
    chk("ill_flags", {res_valid, res_illegal, res_bit}, {1'b1, 1'b1, 1'b0});
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("rst_mid", res_valid, 0);
    res_ready = 1; br_valid = 1; slt_valid = 1; br_op = 3'b000; br_tag = 1; slt_tag = 2;
    #1 chk("rst_rr", {br_ready, slt_ready}, 2'b10);
    cyc();
    br_valid = 0; slt_valid = 0;
    chk("rst_rr_src", {res_src, res_tag}, {1'b0, 5'd1});
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
